// File: rtl/xaui_rx_sync_mon.sv
// XAUI receive monitor: per-lane code-group sync, ||A|| column deskew and code-error count.
// Define XAUI_RX_ERRCNT_EN to build the saturating err_count; otherwise err_count is tied to 0.
module xaui_rx_sync_mon #(
  parameter int ALIGN_COLS = 4,
  parameter int ERR_LIMIT  = 4
) (
  input  logic        xaui_clk,
  input  logic        reset,
  input  logic [63:0] mgt_rxdata,
  input  logic [7:0]  mgt_rxcharisk,
  input  logic [7:0]  mgt_rxcodecomma,
  input  logic [7:0]  mgt_rxcodevalid,
  input  logic        err_clr,
  output logic [3:0]  mgt_rxencommaalign,
  output logic        mgt_rxenchansync,
  output logic [3:0]  lane_sync,
  output logic        align_status,
  output logic [15:0] err_count
);

  typedef enum logic [2:0] {LOSS, CD1, CD2, CD3, SYNC} lane_state_e;
  typedef enum logic [1:0] {ALOSS, ADET, ALIGNED} align_state_e;

  localparam logic [1:0] BAD_MAX  = 2'(ERR_LIMIT - 1);
  localparam logic [3:0] COLS_MAX = 4'(ALIGN_COLS);

  lane_state_e  lane_state_q [4];
  lane_state_e  lane_state_d [4];
  logic [1:0]   bad_cnt_q    [4];
  logic [1:0]   bad_cnt_d    [4];
  logic [1:0]   good_cnt_q   [4];
  logic [1:0]   good_cnt_d   [4];
  logic [3:0]   lane_bad;
  logic [3:0]   lane_comma;

  logic [3:0]   lane_sync_q, lane_sync_d;
  logic [3:0]   comma_align_q, comma_align_d;
  logic         chan_sync_q, chan_sync_d;

  align_state_e align_state_q, align_state_d;
  logic [3:0]   acnt_q, acnt_d;
  logic [1:0]   mis_q, mis_d;
  logic         align_status_q, align_status_d;

  logic [7:0]   byte_is_a;
  logic [1:0]   slot_col;
  logic         a_col;
  logic         a_part;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_bad[i]     = ~mgt_rxcodevalid[2*i] | ~mgt_rxcodevalid[2*i+1];
      lane_comma[i]   = mgt_rxcodecomma[2*i] | mgt_rxcodecomma[2*i+1];
      lane_state_d[i] = lane_state_q[i];
      bad_cnt_d[i]    = bad_cnt_q[i];
      good_cnt_d[i]   = good_cnt_q[i];

      if (lane_state_q[i] == SYNC) begin
        if (lane_bad[i]) begin
          good_cnt_d[i] = '0;
          if (bad_cnt_q[i] == BAD_MAX) begin
            lane_state_d[i] = LOSS;
            bad_cnt_d[i]    = '0;
          end else begin
            bad_cnt_d[i] = bad_cnt_q[i] + 2'd1;
          end
        end else if (bad_cnt_q[i] != '0) begin
          // Four consecutive good cycles forgive one earlier bad cycle.
          if (good_cnt_q[i] == 2'd3) begin
            bad_cnt_d[i]  = bad_cnt_q[i] - 2'd1;
            good_cnt_d[i] = '0;
          end else begin
            good_cnt_d[i] = good_cnt_q[i] + 2'd1;
          end
        end
      end else if (lane_bad[i]) begin
        lane_state_d[i] = LOSS;
      end else if (lane_comma[i]) begin
        case (lane_state_q[i])
          LOSS:    lane_state_d[i] = CD1;
          CD1:     lane_state_d[i] = CD2;
          CD2:     lane_state_d[i] = CD3;
          default: lane_state_d[i] = SYNC;
        endcase
        bad_cnt_d[i]  = '0;
        good_cnt_d[i] = '0;
      end

      lane_sync_d[i] = (lane_state_d[i] == SYNC);
    end
    comma_align_d = ~lane_sync_d;
    chan_sync_d   = &lane_sync_d;
  end

  // Byte b belongs to lane b/2, slot b%2; an ||A|| is K28.3 flagged as a K character.
  always_comb begin
    for (int b = 0; b < 8; b++) begin
      byte_is_a[b] = (mgt_rxdata[8*b +: 8] == 8'h7C) & mgt_rxcharisk[b];
    end
  end

  assign slot_col[0] = byte_is_a[0] & byte_is_a[2] & byte_is_a[4] & byte_is_a[6];
  assign slot_col[1] = byte_is_a[1] & byte_is_a[3] & byte_is_a[5] & byte_is_a[7];
  assign a_col       = |slot_col;
  assign a_part      = (|byte_is_a) & ~a_col;

  always_comb begin
    align_state_d = align_state_q;
    acnt_d        = acnt_q;
    mis_d         = mis_q;
    if (!chan_sync_q) begin
      align_state_d = ALOSS;
      acnt_d        = '0;
      mis_d         = '0;
    end else begin
      case (align_state_q)
        ALOSS: begin
          if (a_col) begin
            align_state_d = ADET;
            acnt_d        = 4'd1;
          end
        end
        ADET: begin
          if (a_part) begin
            align_state_d = ALOSS;
            acnt_d        = '0;
          end else if (a_col) begin
            acnt_d = acnt_q + 4'd1;
            if (acnt_q + 4'd1 == COLS_MAX) begin
              align_state_d = ALIGNED;
              mis_d         = '0;
            end
          end
        end
        ALIGNED: begin
          if (a_col) begin
            mis_d = '0;
          end else if (a_part) begin
            if (mis_q == BAD_MAX) begin
              align_state_d = ALOSS;
              acnt_d        = '0;
              mis_d         = '0;
            end else begin
              mis_d = mis_q + 2'd1;
            end
          end
        end
        default: begin
          align_state_d = ALOSS;
          acnt_d        = '0;
          mis_d         = '0;
        end
      endcase
    end
    align_status_d = (align_state_d == ALIGNED);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge xaui_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        lane_state_q[i] <= LOSS;
        bad_cnt_q[i]    <= '0;
        good_cnt_q[i]   <= '0;
      end
      lane_sync_q    <= '0;
      comma_align_q  <= 4'hF;
      chan_sync_q    <= 1'b0;
      align_state_q  <= ALOSS;
      acnt_q         <= '0;
      mis_q          <= '0;
      align_status_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        lane_state_q[i] <= lane_state_d[i];
        bad_cnt_q[i]    <= bad_cnt_d[i];
        good_cnt_q[i]   <= good_cnt_d[i];
      end
      lane_sync_q    <= lane_sync_d;
      comma_align_q  <= comma_align_d;
      chan_sync_q    <= chan_sync_d;
      align_state_q  <= align_state_d;
      acnt_q         <= acnt_d;
      mis_q          <= mis_d;
      align_status_q <= align_status_d;
    end
  end

  assign lane_sync          = lane_sync_q;
  assign mgt_rxencommaalign = comma_align_q;
  assign mgt_rxenchansync   = chan_sync_q;
  assign align_status       = align_status_q;

`ifdef XAUI_RX_ERRCNT_EN
  logic [15:0] err_count_q, err_count_d;
  logic        sync_err;

  always_comb begin
    sync_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sync_err = sync_err | ((lane_state_q[i] == SYNC) & lane_bad[i]);
    end
    err_count_d = err_count_q;
    if (err_clr) begin
      err_count_d = '0;
    end else if (sync_err && err_count_q != 16'hFFFF) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge xaui_clk or posedge reset) begin
    if (reset) err_count_q <= '0;
    else       err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_count      = '0;
`endif

endmodule
